// File: rtl/keypad_scanner.sv
// Scans a 4x4 active-low keypad, debounces whole-scan results and reports accepted keys.
// Latency: key_valid one cycle after the DB_SCANS-th matching scan evaluation.
// Backpressure: none; key_valid is a single-cycle tick the consumer must take.
module keypad_scanner #(
    parameter int SCAN_DIV = 100_000,
    parameter int DB_SCANS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int               DIV_W    = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [3:0]       DB_MAX   = 4'(DB_SCANS);

    typedef enum logic [1:0] {
        CAND_NONE,
        CAND_KEY,
        CAND_MULTI
    } cand_kind_t;

    typedef enum logic {
        IDLE,
        PRESSED
    } state_t;

    // Row lines are asynchronous to clk.
    logic [3:0] row_meta;
    logic [3:0] row_sync;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_meta <= 4'hF;
            row_sync <= 4'hF;
        end else begin
            row_meta <= row;
            row_sync <= row_meta;
        end
    end

    logic [DIV_W-1:0] div_cnt;
    logic [1:0]       col_idx;
    logic             tc;
    logic             eval;

    assign tc   = (div_cnt == DIV_LAST);
    assign eval = tc && (col_idx == 2'd3);
    assign col  = ~(4'b0001 << col_idx);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
            col_idx <= 2'd0;
        end else if (tc) begin
            div_cnt <= '0;
            col_idx <= col_idx + 2'd1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Column 3 is never stored: its rows are used directly on the evaluation cycle.
    logic [11:0] snapshot;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            snapshot <= '0;
        end else if (tc) begin
            case (col_idx)
                2'd0:    snapshot[3:0]  <= ~row_sync;
                2'd1:    snapshot[7:4]  <= ~row_sync;
                2'd2:    snapshot[11:8] <= ~row_sync;
                default: ;
            endcase
        end
    end

    logic [15:0] scan_full;
    logic        scan_any;
    logic        scan_multi;
    logic [3:0]  scan_pos;
    cand_kind_t  cls_kind;

    assign scan_full = {~row_sync, snapshot};

    always_comb begin
        scan_any   = 1'b0;
        scan_multi = 1'b0;
        scan_pos   = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (scan_full[i]) begin
                if (scan_any) begin
                    scan_multi = 1'b1;
                end
                scan_any = 1'b1;
                scan_pos = 4'(i);
            end
        end
    end

    always_comb begin
        cls_kind = CAND_NONE;
        if (scan_multi) begin
            cls_kind = CAND_MULTI;
        end else if (scan_any) begin
            cls_kind = CAND_KEY;
        end
    end

    cand_kind_t cand_kind;
    cand_kind_t cand_kind_n;
    logic [3:0] cand_key;
    logic [3:0] cand_key_n;
    logic [3:0] stab_cnt;
    logic [3:0] stab_cnt_n;
    logic       cand_same;
    logic       accept;

    assign cand_same = (cls_kind == cand_kind) &&
                       ((cls_kind != CAND_KEY) || (scan_pos == cand_key));

    always_comb begin
        cand_kind_n = cand_kind;
        cand_key_n  = cand_key;
        stab_cnt_n  = stab_cnt;
        if (cls_kind == CAND_MULTI) begin
            cand_kind_n = CAND_MULTI;
            cand_key_n  = 4'd0;
            stab_cnt_n  = 4'd0;
        end else if (cand_same) begin
            stab_cnt_n = (stab_cnt == DB_MAX) ? DB_MAX : stab_cnt + 4'd1;
        end else begin
            cand_kind_n = cls_kind;
            cand_key_n  = (cls_kind == CAND_KEY) ? scan_pos : 4'd0;
            stab_cnt_n  = 4'd1;
        end
    end

    // Only the evaluation that first brings the count to DB_SCANS accepts.
    assign accept = eval && (cls_kind != CAND_MULTI) && (stab_cnt_n == DB_MAX) &&
                    !(cand_same && (stab_cnt == DB_MAX));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cand_kind <= CAND_NONE;
            cand_key  <= 4'd0;
            stab_cnt  <= 4'd0;
        end else if (eval) begin
            cand_kind <= cand_kind_n;
            cand_key  <= cand_key_n;
            stab_cnt  <= stab_cnt_n;
        end
    end

    state_t     state;
    state_t     state_n;
    logic [3:0] code_q;
    logic [3:0] code_n;
    logic       valid_q;
    logic       valid_n;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            code_q  <= 4'd0;
            valid_q <= 1'b0;
        end else begin
            state   <= state_n;
            code_q  <= code_n;
            valid_q <= valid_n;
        end
    end

    always_comb begin
        state_n = state;
        code_n  = code_q;
        valid_n = 1'b0;
        case (state)
            IDLE: begin
                if (accept && (cls_kind == CAND_KEY)) begin
                    state_n = PRESSED;
                    code_n  = scan_pos;
                    valid_n = 1'b1;
                end
            end
            PRESSED: begin
                if (accept) begin
                    if (cls_kind == CAND_NONE) begin
                        state_n = IDLE;
                    end else if (scan_pos != code_q) begin
                        code_n  = scan_pos;
                        valid_n = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign key_code  = code_q;
    assign key_valid = valid_q;
    assign key_held  = (state == PRESSED);

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner with SCAN_DIV=8, DB_SCANS=3: keypad model, tick scoreboard, vector table.
module tb_keypad_scanner;

    localparam int SCAN_DIV = 8;
    localparam int DB_SCANS = 3;
    localparam int SCAN     = 4 * SCAN_DIV;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] pressed;
    logic        force_en;
    logic [3:0]  force_row;

    int cyc;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] code;
        int         at;
    } exp_t;

    typedef struct {
        logic [15:0] mask;
        int          scans;
        logic        tick;
        logic [3:0]  code;
    } vec_t;

    exp_t sbq[$];
    exp_t mon_e;

    keypad_scanner #(
        .SCAN_DIV(SCAN_DIV),
        .DB_SCANS(DB_SCANS)
    ) dut (
        .clk      (clk),
        .reset    (rst_n),
        .row      (row),
        .col      (col),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    always #5 clk = ~clk;

    // Keypad matrix: a pressed key shorts its row to its column when that column is driven low.
    always_comb begin
        row = 4'hF;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (!col[c] && pressed[c*4+r]) row[r] = 1'b0;
            end
        end
        if (force_en) row = force_row;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic push_exp(input logic [3:0] code, input int at);
        exp_t x;
        x.code = code;
        x.at   = at;
        sbq.push_back(x);
    endtask

    task automatic wait_cyc(input int target);
        int n = 0;
        while (cyc != target && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (cyc != target) begin
            checks++;
            errors++;
            $display("FAIL wait_cyc: cyc %0d, target %0d", cyc, target);
        end
    endtask

    task automatic wait_phase(input int p);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((cyc % SCAN) != p && n < 100);
        if ((cyc % SCAN) != p) begin
            checks++;
            errors++;
            $display("FAIL wait_phase: cyc %0d, phase %0d", cyc, p);
        end
    endtask

    // Tick monitor: every key_valid must match the oldest expected tick in code and cycle.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (sbq.size() > 0 && sbq[0].at < cyc) begin
                checks++;
                errors++;
                $display("FAIL missed_tick: expected code %0d at cyc %0d, still absent at %0d",
                         sbq[0].code, sbq[0].at, cyc);
                void'(sbq.pop_front());
            end
            if (key_valid === 1'b1) begin
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_tick: code %0d at cyc %0d, none expected", key_code, cyc);
                end else begin
                    mon_e = sbq.pop_front();
                    if (key_code !== mon_e.code || cyc != mon_e.at) begin
                        errors++;
                        $display("FAIL tick: code %0d at cyc %0d, expected code %0d at cyc %0d",
                                 key_code, cyc, mon_e.code, mon_e.at);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       vecs[5];
        int         base;
        logic [3:0] exp_col;

        vecs[0] = '{16'h0200, 5, 1'b1, 4'd9};   // col 2 row 1
        vecs[1] = '{16'h0001, 4, 1'b1, 4'd0};   // col 0 row 0
        vecs[2] = '{16'h0020, 2, 1'b0, 4'd0};   // too short to accept
        vecs[3] = '{16'h0042, 5, 1'b0, 4'd0};   // two keys: never accepted
        vecs[4] = '{16'h8000, 3, 1'b1, 4'd15};  // col 3 row 3

        rst_n     = 1'b0;
        pressed   = 16'h0;
        force_en  = 1'b0;
        force_row = 4'hF;
        repeat (3) @(negedge clk);
        chk("rst_col", 32'(col), 32'hE);
        chk("rst_code", 32'(key_code), 32'd0);
        chk("rst_valid", 32'(key_valid), 32'd0);
        chk("rst_held", 32'(key_held), 32'd0);
        rst_n = 1'b1;

        // Idle scanning.
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            exp_col = ~(4'b0001 << ((cyc / SCAN_DIV) % 4));
            chk("idle_col", 32'(col), 32'(exp_col));
            chk("idle_valid", 32'(key_valid), 32'd0);
            chk("idle_held", 32'(key_held), 32'd0);
        end

        // Single-pattern press/release table.
        for (int i = 0; i < 5; i++) begin
            wait_phase(1);
            base    = cyc - 1;
            pressed = vecs[i].mask;
            if (vecs[i].tick) push_exp(vecs[i].code, base + DB_SCANS * SCAN);
            wait_cyc(base + vecs[i].scans * SCAN + 1);
            chk("vec_held", 32'(key_held), 32'(vecs[i].tick));
            chk("vec_code", 32'(key_code), 32'(vecs[i].code));
            pressed = 16'h0;
            base    = cyc - 1;
            wait_cyc(base + DB_SCANS * SCAN - 1);
            chk("rel_held_before", 32'(key_held), 32'(vecs[i].tick));
            wait_cyc(base + DB_SCANS * SCAN);
            chk("rel_held_after", 32'(key_held), 32'd0);
            wait_cyc(base + 4 * SCAN + 1);
            chk("rel_code_kept", 32'(key_code), 32'(vecs[i].code));
        end

        // Bounce on col 0 row 3, stable from the fifth scan.
        wait_phase(1);
        base = cyc - 1;
        push_exp(4'd3, base + 7 * SCAN);
        for (int s = 0; s < 7; s++) begin
            if (s > 0) chk("bounce_held", 32'(key_held), 32'd0);
            pressed = (s == 1 || s == 3) ? 16'h0000 : 16'h0008;
            wait_cyc(base + (s + 1) * SCAN + 1);
        end
        chk("bounce_held_end", 32'(key_held), 32'd1);
        chk("bounce_code", 32'(key_code), 32'd3);
        pressed = 16'h0;
        base    = cyc - 1;
        wait_cyc(base + 4 * SCAN + 1);
        chk("bounce_rel", 32'(key_held), 32'd0);

        // Roll-over: (1,0) accepted, (3,3) added, (1,0) released.
        wait_phase(1);
        base    = cyc - 1;
        pressed = 16'h0010;
        push_exp(4'd4, base + DB_SCANS * SCAN);
        wait_cyc(base + DB_SCANS * SCAN + 1);
        chk("roll_first_code", 32'(key_code), 32'd4);
        pressed = 16'h8010;
        for (int k = 0; k < 3 * SCAN; k++) begin
            @(negedge clk);
            chk("roll_multi_held", 32'(key_held), 32'd1);
        end
        pressed = 16'h8000;
        base    = cyc - 1;
        push_exp(4'd15, base + DB_SCANS * SCAN);
        for (int k = 0; k < 3 * SCAN + 1; k++) begin
            @(negedge clk);
            chk("roll_held", 32'(key_held), 32'd1);
        end
        chk("roll_code", 32'(key_code), 32'd15);
        pressed = 16'h0;
        base    = cyc - 1;
        wait_cyc(base + 4 * SCAN + 1);
        chk("roll_rel", 32'(key_held), 32'd0);

        // Sample point: a row change one cycle before terminal count is too late.
        for (int s = 0; s < 4; s++) begin
            wait_phase(6);
            force_row = 4'hE;
            force_en  = 1'b1;
            wait_phase(9);
            force_en  = 1'b0;
        end
        wait_phase(1);
        chk("late_held", 32'(key_held), 32'd0);

        // Two cycles before terminal count is early enough.
        wait_phase(5);
        base = cyc - 5;
        push_exp(4'd0, base + DB_SCANS * SCAN);
        for (int s = 0; s < 3; s++) begin
            if (s > 0) wait_phase(5);
            force_row = 4'hE;
            force_en  = 1'b1;
            wait_phase(8);
            force_en  = 1'b0;
        end
        wait_phase(1);
        chk("early_held", 32'(key_held), 32'd1);
        chk("early_code", 32'(key_code), 32'd0);
        base = cyc - 1;
        wait_cyc(base + 4 * SCAN + 1);
        chk("early_rel", 32'(key_held), 32'd0);

        // Reset while (1,2) is held, then re-detection.
        wait_phase(1);
        base    = cyc - 1;
        pressed = 16'h0040;
        push_exp(4'd6, base + DB_SCANS * SCAN);
        wait_cyc(base + DB_SCANS * SCAN + 11);
        chk("pre_rst_held", 32'(key_held), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_col", 32'(col), 32'hE);
        chk("async_rst_code", 32'(key_code), 32'd0);
        chk("async_rst_valid", 32'(key_valid), 32'd0);
        chk("async_rst_held", 32'(key_held), 32'd0);
        repeat (3) @(negedge clk);
        chk("in_rst_held", 32'(key_held), 32'd0);
        rst_n = 1'b1;
        push_exp(4'd6, DB_SCANS * SCAN);
        wait_cyc(DB_SCANS * SCAN + 1);
        chk("post_rst_held", 32'(key_held), 32'd1);
        chk("post_rst_code", 32'(key_code), 32'd6);
        pressed = 16'h0;
        base    = cyc - 1;
        wait_cyc(base + 4 * SCAN + 1);
        chk("post_rst_rel", 32'(key_held), 32'd0);

        chk("sb_drained", 32'(sbq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Scans a 4x4 matrix keypad, such as a Pmod KYPD, by driving one column low at a time and reading the four row lines.
- Debounces the scan results and reports one debounced key press as a 4-bit code with a one-cycle valid tick.
- Fills the input side of the board I/O: it reads a time-multiplexed interface, where the display driver writes one. Its tick feeds the counters and the display path directly.

Parameters:
- SCAN_DIV, default 100_000: clock cycles each column is driven (1 ms at 100 MHz). Minimum legal value is 4.
- DB_SCANS, default 4: number of consecutive identical full-scan evaluations required to accept a press or a release. Range 1..15.

Ports:
- clk  input  1  system clock, generally 100 MHz
- reset  input  1  asynchronous, active-low reset
- row  input  4  keypad row lines, active-low, externally pulled up; asynchronous to clk
- col  output  4  keypad column drive, active-low, one-hot-low
- key_code  output  4  code of the last accepted key = col_idx*4 + row_idx
- key_valid  output  1  one-cycle tick when a new key is accepted
- key_held  output  1  level, high while the accepted key is still debounced-pressed

Behaviour:
- Reset (reset=0, asynchronous):
  - col=4'b1110, key_code=0, key_valid=0, key_held=0.
  - Column index, divider, snapshot, candidate and stability counter all clear to 0; candidate = NONE.
- Input sync: row passes through a 2-FF synchronizer before any use.
- Column drive:
  - col_idx 0..3; col = ~(1<<col_idx).
  - The divider counts 0..SCAN_DIV-1. At terminal count, col_idx advances 3->0 with wrap, and the divider restarts.
- Sampling:
  - On the divider terminal-count cycle, the synchronized rows are stored into snapshot[col_idx*4 +: 4], inverted so that 1 = pressed.
  - Sampling at end-of-period gives settling time for the column drive and the synchronizer.
- Evaluation: on the terminal-count cycle of col_idx=3, the completed 16-bit snapshot is classified, using the row sampled that same cycle for column 3.
  - Zero bits set -> NONE.
  - Exactly one bit set at position p -> KEY(p).
  - Two or more bits set -> MULTI.
- Debounce state machine. States: IDLE (nothing accepted), PRESSED (key accepted, key_held=1).
  - The classification is compared with the stored candidate:
    - Equal: the stability counter increments, saturating at DB_SCANS.
    - Different: the candidate is replaced and the counter is set to 1.
    - MULTI: the candidate is set to MULTI and the counter is set to 0. MULTI never reaches acceptance, so outputs hold.
  - IDLE -> PRESSED when the candidate is KEY(p) and the counter reaches DB_SCANS. Next cycle: key_code=p, key_valid=1 for exactly 1 cycle, key_held=1.
  - PRESSED, candidate KEY(q) with q≠key_code, counter reaches DB_SCANS: roll-over. Stay PRESSED, key_code=q, key_valid pulses once.
  - PRESSED -> IDLE when the candidate is NONE and the counter reaches DB_SCANS. key_held drops the next cycle; key_code retains its last value; no tick.
  - Acceptance fires only on the evaluation where the counter first equals DB_SCANS. A held key never re-ticks.
- Latency:
  - key_valid asserts 1 cycle after the DB_SCANS-th consecutive matching evaluation.
  - Worst-case press-to-tick time is (DB_SCANS+1)*4*SCAN_DIV+3 cycles.
- Bounce shorter than DB_SCANS scans produces no tick and no key_held change.
- Reset mid-scan: everything returns to reset values immediately. A key held through reset is re-detected and ticks once after DB_SCANS scans.

Test Plan (SCAN_DIV=8, DB_SCANS=3):
- Reset released, no key pressed -> col cycles 1110,1101,1011,0111 with 8 cycles each, repeating; key_valid and key_held stay 0 for 1000 cycles.
- Hold key (col 2, row 1) steady -> exactly one key_valid pulse with key_code=9, issued 1 cycle after the 3rd matching evaluation; key_held=1 while held. After release, key_held falls after 3 NONE evaluations, with no further tick.
- Bounce on key (col 0, row 3) toggling every scan for 5 scans, then stable -> no tick during the bounce; one tick with key_code=3 after 3 stable scans.
- Hold (col 1, row 0) until accepted (key_code=4), then press (col 3, row 3) as well, then release (1,0) -> no tick while both are pressed; one tick with key_code=15 after 3 scans of (3,3) alone; key_held stays 1 throughout.
- Assert reset for 3 cycles while key (col 1, row 2) is held and key_held=1 -> outputs go to reset values asynchronously; after release, one new tick with key_code=6.
- Row lines change 1 cycle before the terminal count -> the old value is sampled (2-FF latency); checks the synchronizer path and the sample point.
